// File: rtl/spi_trace_encoder_pkg.sv
// Shared definitions for the SPI trace encoder: record layout, ASCII constants
// and the record-to-character mapping used by the UART serialiser.
package spi_trace_encoder_pkg;

   localparam int unsigned RecW    = 48;
   localparam int unsigned LineLen = 16;

   localparam logic [7:0] AsciiCr    = 8'h0D;
   localparam logic [7:0] AsciiLf    = 8'h0A;
   localparam logic [7:0] AsciiSpace = 8'h20;

   // Capture FSM encoding. CapCmd is reserved: the start strobe already carries
   // the command byte, so capture moves straight from CapIdle to CapAddr.
   localparam logic [1:0] CapIdle = 2'd0;
   localparam logic [1:0] CapCmd  = 2'd1;
   localparam logic [1:0] CapAddr = 2'd2;
   localparam logic [1:0] CapData = 2'd3;

   typedef struct packed {
      logic [7:0]  cmd;
      logic [23:0] addr;
      logic [15:0] len;
   } trace_rec_t;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

   // Character idx of the line "CC AAAAAA LLLL\r\n" for one record.
   function automatic logic [7:0] line_char(input trace_rec_t rec, input logic [3:0] idx);
      logic [7:0] c;
      case (idx)
         4'd0:    c = hex_char(rec.cmd[7:4]);
         4'd1:    c = hex_char(rec.cmd[3:0]);
         4'd2:    c = AsciiSpace;
         4'd3:    c = hex_char(rec.addr[23:20]);
         4'd4:    c = hex_char(rec.addr[19:16]);
         4'd5:    c = hex_char(rec.addr[15:12]);
         4'd6:    c = hex_char(rec.addr[11:8]);
         4'd7:    c = hex_char(rec.addr[7:4]);
         4'd8:    c = hex_char(rec.addr[3:0]);
         4'd9:    c = AsciiSpace;
         4'd10:   c = hex_char(rec.len[15:12]);
         4'd11:   c = hex_char(rec.len[11:8]);
         4'd12:   c = hex_char(rec.len[7:4]);
         4'd13:   c = hex_char(rec.len[3:0]);
         4'd14:   c = AsciiCr;
         default: c = AsciiLf;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read: rd_data always presents the oldest
// entry while empty is low. Writes when full and reads when empty are ignored.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_wr;
   logic             do_rd;

   // Extra pointer bit separates full from empty when the indices coincide.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         end
         if (do_rd) begin
            rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/spi_trace_encoder.sv
// Captures SPI transactions as {cmd, addr, len} records, buffers them, and
// prints each one to the UART as an uppercase-hex ASCII line.
module spi_trace_encoder #(
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_cs,
   input  logic       spi_start_strobe,
   input  logic       spi_byte_strobe,
   input  logic [7:0] spi_byte,
   output logic [7:0] uart_tx,
   output logic       uart_tx_strobe,
   input  logic       uart_tx_ready,
   output logic [7:0] dropped_count
);

   import spi_trace_encoder_pkg::*;

   logic [1:0]     cap_state_q;
   logic [7:0]     cmd_q;
   logic [23:0]    addr_q;
   logic [1:0]     addr_cnt_q;
   logic [15:0]    len_q;
   logic           in_txn;
   logic           wr_q;
   trace_rec_t     wr_rec_q;

   logic           fifo_full;
   logic           fifo_empty;
   logic           fifo_rd;
   logic [RecW-1:0] fifo_rd_data;

   logic           busy_q;
   logic           strobe_prev_q;
   logic [3:0]     idx_q;
   trace_rec_t     line_q;
   logic [7:0]     tx_q;
   logic           tx_strobe;
   logic [7:0]     dropped_q;

   assign in_txn = (cap_state_q == CapAddr) || (cap_state_q == CapData);

   always_ff @(posedge clk) begin
      if (reset) begin
         cap_state_q <= CapIdle;
         cmd_q       <= '0;
         addr_q      <= '0;
         addr_cnt_q  <= '0;
         len_q       <= '0;
         wr_q        <= 1'b0;
         wr_rec_q    <= '0;
      end else begin
         wr_q <= 1'b0;
         if (spi_start_strobe) begin
            // A new command closes any open record in the same cycle.
            if (in_txn) begin
               wr_q     <= 1'b1;
               wr_rec_q <= {cmd_q, addr_q, len_q};
            end
            cmd_q       <= spi_byte;
            addr_q      <= '0;
            addr_cnt_q  <= '0;
            len_q       <= '0;
            cap_state_q <= CapAddr;
         end else if (spi_cs && in_txn) begin
            wr_q        <= 1'b1;
            wr_rec_q    <= {cmd_q, addr_q, len_q};
            cap_state_q <= CapIdle;
         end else if (spi_byte_strobe) begin
            case (cap_state_q)
               CapAddr: begin
                  // Bytes land from the top so a short address is zero-padded below.
                  case (addr_cnt_q)
                     2'd0:    addr_q[23:16] <= spi_byte;
                     2'd1:    addr_q[15:8]  <= spi_byte;
                     default: addr_q[7:0]   <= spi_byte;
                  endcase
                  addr_cnt_q <= addr_cnt_q + 2'd1;
                  if (addr_cnt_q == 2'd2) begin
                     cap_state_q <= CapData;
                  end
               end
               CapData: begin
                  if (len_q != 16'hFFFF) begin
                     len_q <= len_q + 16'd1;
                  end
               end
               CapIdle, CapCmd: ;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dropped_q <= '0;
      end else if (wr_q && fifo_full && (dropped_q != 8'hFF)) begin
         dropped_q <= dropped_q + 8'd1;
      end
   end

   sync_fifo #(
      .WIDTH (RecW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_q),
      .wr_data (wr_rec_q),
      .full    (fifo_full),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rd_data),
      .empty   (fifo_empty)
   );

   // Records stay in the FIFO while the UART is stalled, so buffering is
   // exactly FIFO_DEPTH lines deep.
   assign fifo_rd   = !busy_q && !fifo_empty && uart_tx_ready && !reset;
   assign tx_strobe = busy_q && uart_tx_ready && !strobe_prev_q && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q        <= 1'b0;
         strobe_prev_q <= 1'b0;
         idx_q         <= '0;
         line_q        <= '0;
         tx_q          <= '0;
      end else begin
         strobe_prev_q <= tx_strobe;
         if (fifo_rd) begin
            busy_q <= 1'b1;
            idx_q  <= '0;
            line_q <= trace_rec_t'(fifo_rd_data);
            tx_q   <= line_char(trace_rec_t'(fifo_rd_data), 4'd0);
         end else if (tx_strobe) begin
            if (idx_q == 4'(LineLen - 1)) begin
               busy_q <= 1'b0;
            end else begin
               idx_q <= idx_q + 4'd1;
               tx_q  <= line_char(line_q, idx_q + 4'd1);
            end
         end
      end
   end

   assign uart_tx        = tx_q;
   assign uart_tx_strobe = tx_strobe;
   assign dropped_count  = dropped_q;

endmodule

// File: tb/tb_spi_trace_encoder.sv
// Randomised bench for spi_trace_encoder; expected lines come from a
// formatted-string model of each transaction.
module tb_spi_trace_encoder;

   localparam int unsigned Depth = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       spi_cs;
   logic       spi_start_strobe;
   logic       spi_byte_strobe;
   logic [7:0] spi_byte;
   logic [7:0] uart_tx;
   logic       uart_tx_strobe;
   logic       uart_tx_ready;
   logic [7:0] dropped_count;

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   int unsigned fin_cyc  = 0;
   int          consec   = 0;
   logic        prev_strobe = 1'b0;
   logic [7:0]  rx_q[$];
   int unsigned rx_cyc_q[$];

   spi_trace_encoder #(
      .FIFO_DEPTH (Depth)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .spi_cs           (spi_cs),
      .spi_start_strobe (spi_start_strobe),
      .spi_byte_strobe  (spi_byte_strobe),
      .spi_byte         (spi_byte),
      .uart_tx          (uart_tx),
      .uart_tx_strobe   (uart_tx_strobe),
      .uart_tx_ready    (uart_tx_ready),
      .dropped_count    (dropped_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (uart_tx_strobe === 1'b1) begin
         rx_q.push_back(uart_tx);
         rx_cyc_q.push_back(cyc);
         if (prev_strobe === 1'b1) consec <= consec + 1;
      end
      prev_strobe <= uart_tx_strobe;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      spi_cs = 1'b1;
      spi_start_strobe = 1'b0;
      spi_byte_strobe = 1'b0;
      spi_byte = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      rx_q.delete();
      rx_cyc_q.delete();
   endtask

   // Payload byte i < 3 comes from abytes (top byte first); later bytes are random data.
   task automatic send_txn(input logic [7:0] cmd, input logic [23:0] abytes, input int n,
                           input bit close);
      spi_cs = 1'b0;
      spi_start_strobe = 1'b1;
      spi_byte = cmd;
      tick();
      spi_start_strobe = 1'b0;
      for (int i = 0; i < n; i++) begin
         spi_byte_strobe = 1'b1;
         spi_byte = (i < 3) ? abytes[23 - 8 * i -: 8] : 8'($urandom);
         tick();
      end
      spi_byte_strobe = 1'b0;
      if (close) begin
         spi_cs = 1'b1;
         fin_cyc = cyc;
         tick();
      end
   endtask

   function automatic logic [127:0] model_line(input logic [7:0] cmd, input logic [23:0] abytes,
                                               input int n);
      int          na = (n < 3) ? n : 3;
      int          nd = n - na;
      logic [23:0] addr = (abytes >> (8 * (3 - na))) << (8 * (3 - na));
      logic [15:0] len = (nd > 65535) ? 16'hFFFF : 16'(nd);
      string       s;
      logic [127:0] v = '0;
      s = $sformatf("%h %h %h", cmd, addr, len);
      s = {s.toupper(), "\r\n"};
      for (int i = 0; i < 16; i++) v = {v[119:0], s.getc(i)};
      return v;
   endfunction

   task automatic get_line(output logic [127:0] line, output bit ok,
                           output int unsigned first_cyc, output int unsigned max_gap);
      int          waited = 0;
      int unsigned c;
      int unsigned prev_c = 0;
      line = '0;
      ok = 1'b0;
      first_cyc = 0;
      max_gap = 0;
      while (rx_q.size() < 16 && waited < 400) begin
         tick();
         waited++;
      end
      if (rx_q.size() >= 16) begin
         ok = 1'b1;
         for (int i = 0; i < 16; i++) begin
            c = rx_cyc_q.pop_front();
            line = {line[119:0], rx_q.pop_front()};
            if (i == 0) first_cyc = c;
            else if (c - prev_c > max_gap) max_gap = c - prev_c;
            prev_c = c;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      spi_cs = 1'b1;
      spi_start_strobe = 1'b0;
      spi_byte_strobe = 1'b0;
      spi_byte = '0;
      uart_tx_ready = 1'b1;
      repeat (3) tick();
      checks++;
      if (uart_tx !== 8'h00) begin
         failures++;
         $display("FAIL reset_uart_tx: got %h required 00", uart_tx);
      end
      checks++;
      if (uart_tx_strobe !== 1'b0) begin
         failures++;
         $display("FAIL reset_strobe: got %b required 0", uart_tx_strobe);
      end
      checks++;
      if (dropped_count !== 8'h00) begin
         failures++;
         $display("FAIL reset_dropped: got %h required 00", dropped_count);
      end
      reset = 1'b0;
      for (int i = 0; i < 30; i++) begin
         spi_cs = 1'b1;
         spi_byte_strobe = 1'($urandom);
         spi_byte = 8'($urandom);
         tick();
      end
      spi_byte_strobe = 1'b0;
      repeat (10) tick();
      checks++;
      if (rx_q.size() != 0) begin
         failures++;
         $display("FAIL idle_no_record: got %0d chars required 0", rx_q.size());
      end
   endtask

   task automatic test_basic();
      logic [127:0] got;
      logic [127:0] exp;
      bit           ok;
      int unsigned  first_c;
      int unsigned  gap;
      send_txn(8'h03, 24'h123456, 7, 1'b1);
      exp = model_line(8'h03, 24'h123456, 7);
      get_line(got, ok, first_c, gap);
      checks++;
      if (!ok || got !== exp) begin
         failures++;
         $display("FAIL basic_line: got %h required %h", got, exp);
      end
      checks++;
      if (!ok || first_c - fin_cyc != 3) begin
         failures++;
         $display("FAIL basic_latency: got %0d cycles required 3", first_c - fin_cyc);
      end
      checks++;
      if (!ok || gap > 2) begin
         failures++;
         $display("FAIL basic_spacing: got max gap %0d required <= 2", gap);
      end
      checks++;
      if (consec != 0) begin
         failures++;
         $display("FAIL basic_no_consecutive: got %0d consecutive strobes required 0", consec);
      end
   endtask

   task automatic test_short();
      logic [127:0] got;
      logic [127:0] exp_q[$];
      logic [127:0] exp;
      bit           ok;
      int unsigned  first_c;
      int unsigned  gap;
      logic [7:0]   cmd;
      logic [23:0]  ab;
      int           n;
      send_txn(8'h9F, 24'hAB0000, 1, 1'b1);
      exp_q.push_back(model_line(8'h9F, 24'hAB0000, 1));
      send_txn(8'h05, 24'h000000, 0, 1'b1);
      exp_q.push_back(model_line(8'h05, 24'h000000, 0));
      for (int k = 0; k < 6; k++) begin
         cmd = 8'($urandom);
         ab = 24'($urandom);
         n = int'($urandom_range(0, 40));
         send_txn(cmd, ab, n, 1'b1);
         exp_q.push_back(model_line(cmd, ab, n));
      end
      for (int k = 0; k < 8; k++) begin
         exp = exp_q.pop_front();
         get_line(got, ok, first_c, gap);
         checks++;
         if (!ok || got !== exp) begin
            failures++;
            $display("FAIL short_line%0d: got %h required %h", k, got, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] got;
      logic [127:0] exp;
      bit           ok;
      int unsigned  first_c;
      int unsigned  gap;
      send_txn(8'h06, 24'h000000, 0, 1'b0);
      send_txn(8'h02, 24'h001000, 4, 1'b1);
      exp = model_line(8'h06, 24'h000000, 0);
      get_line(got, ok, first_c, gap);
      checks++;
      if (!ok || got !== exp) begin
         failures++;
         $display("FAIL b2b_first: got %h required %h", got, exp);
      end
      exp = model_line(8'h02, 24'h001000, 4);
      get_line(got, ok, first_c, gap);
      checks++;
      if (!ok || got !== exp) begin
         failures++;
         $display("FAIL b2b_second: got %h required %h", got, exp);
      end
   endtask

   task automatic test_overflow();
      logic [127:0] got;
      logic [127:0] exp_q[$];
      logic [127:0] exp;
      bit           ok;
      int unsigned  first_c;
      int unsigned  gap;
      logic [7:0]   cmd;
      logic [23:0]  ab;
      int           n;
      do_reset();
      uart_tx_ready = 1'b0;
      for (int k = 0; k < Depth + 3; k++) begin
         cmd = 8'($urandom);
         ab = 24'($urandom);
         n = int'($urandom_range(0, 6));
         send_txn(cmd, ab, n, 1'b1);
         if (k < Depth) exp_q.push_back(model_line(cmd, ab, n));
      end
      repeat (4) tick();
      checks++;
      if (dropped_count !== 8'd3) begin
         failures++;
         $display("FAIL overflow_dropped: got %0d required 3", dropped_count);
      end
      checks++;
      if (rx_q.size() != 0) begin
         failures++;
         $display("FAIL overflow_stalled: got %0d chars required 0", rx_q.size());
      end
      uart_tx_ready = 1'b1;
      for (int k = 0; k < Depth; k++) begin
         exp = exp_q.pop_front();
         get_line(got, ok, first_c, gap);
         checks++;
         if (!ok || got !== exp) begin
            failures++;
            $display("FAIL overflow_line%0d: got %h required %h", k, got, exp);
         end
      end
      repeat (60) tick();
      checks++;
      if (rx_q.size() != 0) begin
         failures++;
         $display("FAIL overflow_extra: got %0d chars required 0", rx_q.size());
      end
   endtask

   task automatic test_drop_saturate();
      int waited = 0;
      do_reset();
      uart_tx_ready = 1'b0;
      for (int k = 0; k < Depth + 300; k++) send_txn(8'($urandom), 24'h0, 0, 1'b1);
      repeat (3) tick();
      checks++;
      if (dropped_count !== 8'hFF) begin
         failures++;
         $display("FAIL drop_saturate: got %h required ff", dropped_count);
      end
      uart_tx_ready = 1'b1;
      while (rx_q.size() < 16 * Depth && waited < 3000) begin
         tick();
         waited++;
      end
      repeat (40) tick();
      checks++;
      if (rx_q.size() != 16 * Depth) begin
         failures++;
         $display("FAIL drop_drain: got %0d chars required %0d", rx_q.size(), 16 * Depth);
      end
      rx_q.delete();
      rx_cyc_q.delete();
   endtask

   task automatic test_len_saturate();
      logic [127:0] got;
      logic [127:0] exp;
      bit           ok;
      int unsigned  first_c;
      int unsigned  gap;
      send_txn(8'h0B, 24'hC0FFEE, 3 + 70000, 1'b1);
      exp = model_line(8'h0B, 24'hC0FFEE, 3 + 70000);
      get_line(got, ok, first_c, gap);
      checks++;
      if (!ok || got !== exp) begin
         failures++;
         $display("FAIL len_saturate: got %h required %h", got, exp);
      end
   endtask

   task automatic test_reset_midline();
      logic [127:0] got;
      logic [127:0] exp;
      bit           ok;
      int unsigned  first_c;
      int unsigned  gap;
      int           waited = 0;
      send_txn(8'hA5, 24'h654321, 5, 1'b1);
      while (rx_q.size() < 5 && waited < 100) begin
         tick();
         waited++;
      end
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      repeat (40) tick();
      checks++;
      if (rx_q.size() != 5) begin
         failures++;
         $display("FAIL midreset_chars: got %0d chars required 5", rx_q.size());
      end
      checks++;
      if (dropped_count !== 8'h00) begin
         failures++;
         $display("FAIL midreset_dropped: got %h required 00", dropped_count);
      end
      checks++;
      if (uart_tx !== 8'h00) begin
         failures++;
         $display("FAIL midreset_uart_tx: got %h required 00", uart_tx);
      end
      rx_q.delete();
      rx_cyc_q.delete();
      send_txn(8'h3C, 24'hBEEF01, 9, 1'b1);
      exp = model_line(8'h3C, 24'hBEEF01, 9);
      get_line(got, ok, first_c, gap);
      checks++;
      if (!ok || got !== exp) begin
         failures++;
         $display("FAIL midreset_next_line: got %h required %h", got, exp);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short();
      test_back_to_back();
      test_overflow();
      test_drop_saturate();
      test_len_saturate();
      test_reset_midline();
      checks++;
      if (consec != 0) begin
         failures++;
         $display("FAIL no_consecutive_strobes: got %0d required 0", consec);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
